// File: rtl/rs_syndrome_calc_pkg.sv
// Shared GF(2^8) definitions for the Reed-Solomon syndrome datapath.
// Field arithmetic helpers live here so the LUT and multiplier stay trivial.
package rs_pkg;
  localparam int          GF_W      = 8;
  localparam logic [8:0]  PRIM_POLY = 9'h11D;
  localparam int          DEF_N     = 255;
  localparam int          DEF_NSYM  = 16;

  typedef logic [GF_W-1:0] gf_sym_t;

  // Shift-and-add multiply, reducing by the primitive polynomial each step.
  function automatic gf_sym_t gf_mul(input gf_sym_t a, input gf_sym_t b);
    gf_sym_t p;
    gf_sym_t s;
    p = '0;
    s = a;
    for (int k = 0; k < GF_W; k++) begin
      if (b[k]) p = p ^ s;
      s = {s[GF_W-2:0], 1'b0} ^ (s[GF_W-1] ? PRIM_POLY[GF_W-1:0] : '0);
    end
    return p;
  endfunction
endpackage

// File: rtl/rs_syndrome_calc_if.sv
// Symbol-stream input and syndrome-set output handshakes.
interface rs_syndrome_calc_if import rs_pkg::*; #(parameter int NSYM = DEF_NSYM);
  logic              in_valid;
  logic              in_ready;
  gf_sym_t           in_data;
  logic              in_last;
  logic              synd_valid;
  logic              synd_ready;
  logic [NSYM*8-1:0] synd_data;
  logic              synd_nonzero;
  logic              len_err;

  modport master (
    output in_valid, in_data, in_last, synd_ready,
    input  in_ready, synd_valid, synd_data, synd_nonzero, len_err
  );

  modport slave (
    input  in_valid, in_data, in_last, synd_ready,
    output in_ready, synd_valid, synd_data, synd_nonzero, len_err
  );
endinterface

// File: rtl/rs_syndrome_calc_gf.sv
// GF(2^8) building blocks: alpha-power table and constant-operand multiplier.
// Both are driven by constants in the top, so synthesis folds them to XOR trees.
module gf256_power_lut import rs_pkg::*; (
  input  logic [7:0] i_addr,
  output gf_sym_t    o_val
);
  always_comb begin
    o_val = 8'h01;
    for (int k = 0; k < 255; k++) begin
      if (8'(k) < i_addr) o_val = gf_mul(o_val, 8'h02);
    end
  end
endmodule

module gf256_const_mul import rs_pkg::*; (
  input  gf_sym_t i_a,
  input  gf_sym_t i_k,
  output gf_sym_t o_p
);
  assign o_p = gf_mul(i_a, i_k);
endmodule

// File: rtl/rs_syndrome_calc.sv
// Streaming RS syndrome calculator: Horner evaluation at alpha^(FCR+i) per lane,
// with a one-deep output register and zero-bubble reload on codeword boundaries.
module rs_syndrome_calc import rs_pkg::*; #(
  parameter int N    = DEF_N,
  parameter int NSYM = DEF_NSYM,
  parameter int FCR  = 0
) (
  input logic              clk,
  input logic              rst_n,
  rs_syndrome_calc_if.slave bus
);
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]               r_state;
  logic [8:0]               r_cnt;
  logic [NSYM-1:0][7:0]     r_acc;
  logic [NSYM*8-1:0]        r_synd;
  logic                     r_nz;
  logic                     r_len_err;

  logic [NSYM-1:0][7:0]     w_root;
  logic [NSYM-1:0][7:0]     w_prod;
  logic [NSYM-1:0][7:0]     w_nxt;
  logic                     w_in_ready;
  logic                     w_take;
  logic                     w_at_max;
  logic                     w_end;

  for (genvar g = 0; g < NSYM; g++) begin : g_lane
    gf256_power_lut u_lut (
      .i_addr (8'(FCR + g)),
      .o_val  (w_root[g])
    );
    gf256_const_mul u_mul (
      .i_a (r_acc[g]),
      .i_k (w_root[g]),
      .o_p (w_prod[g])
    );
    assign w_nxt[g] = w_prod[g] ^ bus.in_data;
  end

  assign w_in_ready = !((r_state == ST_FULL) && !bus.synd_ready);
  assign w_take     = bus.in_valid && w_in_ready;
  assign w_at_max   = (r_cnt == 9'(N - 1));
  assign w_end      = w_take && (bus.in_last || w_at_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (w_take) begin
      if (w_end) begin
        r_cnt <= '0;
        r_acc <= '0;
      end else begin
        r_cnt <= r_cnt + 9'd1;
        r_acc <= w_nxt;
      end
    end
  end

  // Output register only loads on a codeword end, so held results stay stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_EMPTY;
      r_synd    <= '0;
      r_nz      <= 1'b0;
      r_len_err <= 1'b0;
    end else if (w_end) begin
      r_state   <= ST_FULL;
      r_synd    <= w_nxt;
      r_nz      <= |w_nxt;
      r_len_err <= w_at_max && !bus.in_last;
    end else if ((r_state == ST_FULL) && bus.synd_ready) begin
      r_state   <= ST_EMPTY;
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.synd_valid   = (r_state == ST_FULL);
  assign bus.synd_data    = r_synd;
  assign bus.synd_nonzero = r_nz;
  assign bus.len_err      = r_len_err;
endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Directed bench for rs_syndrome_calc: driver pushes hand-computed syndrome sets,
// a negedge monitor pops and compares on every output handshake.
module tb_rs_syndrome_calc;
  localparam int NSYM = 16;
  localparam int W    = NSYM * 8;

  typedef struct {
    logic [W-1:0] d;
    logic         nz;
    logic         le;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb[$];
  exp_t e;

  // alpha^0 .. alpha^15, S_15 in the top byte
  logic [W-1:0] alpha_v;

  rs_syndrome_calc_if #(.NSYM(NSYM)) bus();

  rs_syndrome_calc #(.N(255), .NSYM(NSYM), .FCR(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] rep(input logic [7:0] b);
    return {NSYM{b}};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push(input logic [W-1:0] d, input logic nz, input logic le);
    exp_t x;
    x.d = d; x.nz = nz; x.le = le;
    sb.push_back(x);
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stuck at 0 for %0d cycles", n);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.synd_valid && bus.synd_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %h expected none", bus.synd_data);
      end else begin
        e = sb.pop_front();
        chk("synd_data", bus.synd_data, e.d);
        chk("synd_nonzero", W'(bus.synd_nonzero), W'(e.nz));
        chk("len_err", W'(bus.len_err), W'(e.le));
      end
    end
  end

  initial begin
    int n;
    checks  = 0;
    errors  = 0;
    alpha_v = {8'h26, 8'h13, 8'h87, 8'hCD, 8'hE8, 8'h74, 8'h3A, 8'h1D,
               8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_last    = 1'b0;
    bus.synd_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", W'(bus.in_ready), W'(1));
    chk("rst_synd_valid", W'(bus.synd_valid), W'(0));
    chk("rst_synd_data", bus.synd_data, '0);
    chk("rst_nonzero", W'(bus.synd_nonzero), W'(0));
    chk("rst_len_err", W'(bus.len_err), W'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // all-zero full-length codeword, in_last on symbol 255
    for (int i = 0; i < 254; i++) send(8'h00, 1'b0);
    chk("zero_pre_valid", W'(bus.synd_valid), W'(0));
    push('0, 1'b0, 1'b0);
    send(8'h00, 1'b1);
    chk("zero_latency_valid", W'(bus.synd_valid), W'(1));
    idle(2);

    // single symbol 0x01
    push(rep(8'h01), 1'b1, 1'b0);
    send(8'h01, 1'b1);
    idle(2);

    // 0x01, 0x00 -> S_i = alpha^i
    push(alpha_v, 1'b1, 1'b0);
    send(8'h01, 1'b0);
    send(8'h00, 1'b1);
    idle(2);

    // 255 symbols without in_last, then a fresh single-symbol codeword
    for (int i = 0; i < 254; i++) send(8'h00, 1'b0);
    push(rep(8'h01), 1'b1, 1'b1);
    send(8'h01, 1'b0);
    chk("lenerr_close_valid", W'(bus.synd_valid), W'(1));
    push(rep(8'h03), 1'b1, 1'b0);
    send(8'h03, 1'b1);
    idle(2);

    // back-to-back single-symbol codewords, no bubble
    push(rep(8'h05), 1'b1, 1'b0);
    push(rep(8'h06), 1'b1, 1'b0);
    push(rep(8'h07), 1'b1, 1'b0);
    send(8'h05, 1'b1);
    chk("b2b_ready_1", W'(bus.in_ready), W'(1));
    send(8'h06, 1'b1);
    chk("b2b_ready_2", W'(bus.in_ready), W'(1));
    send(8'h07, 1'b1);
    chk("b2b_ready_3", W'(bus.in_ready), W'(1));
    idle(2);

    // backpressure: hold result, next codeword stalls until released
    bus.synd_ready = 1'b0;
    push(alpha_v, 1'b1, 1'b0);
    send(8'h01, 1'b0);
    send(8'h00, 1'b1);
    chk("bp_valid", W'(bus.synd_valid), W'(1));
    chk("bp_in_ready_low", W'(bus.in_ready), W'(0));
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h09;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_stall", W'(bus.in_ready), W'(0));
      chk("bp_hold_data", bus.synd_data, alpha_v);
    end
    @(posedge clk); #1;
    push(rep(8'h09), 1'b1, 1'b0);
    bus.synd_ready = 1'b1;
    @(negedge clk);
    chk("bp_resume_ready", W'(bus.in_ready), W'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("bp_reload_valid", W'(bus.synd_valid), W'(1));
    idle(2);

    // reset mid-codeword discards partial state
    for (int i = 0; i < 100; i++) send(8'h11, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", W'(bus.in_ready), W'(1));
    chk("mid_rst_valid", W'(bus.synd_valid), W'(0));
    chk("mid_rst_data", bus.synd_data, '0);
    chk("mid_rst_nonzero", W'(bus.synd_nonzero), W'(0));
    chk("mid_rst_len_err", W'(bus.len_err), W'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    push(rep(8'h05), 1'b1, 1'b0);
    send(8'h05, 1'b1);

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      n++;
      @(posedge clk);
    end
    @(negedge clk);
    chk("scoreboard_drained", W'(sb.size()), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
